nexys4_display_axi_slave: RTL and testbench

AXI4-Lite responder for the Nexys4 eight-digit seven-segment display. It terminates the S00_AXI control port that the block-design master drives, and holds four 32-bit read/write registers. It also runs a prescaled scan engine that time-multiplexes the board's anodes and segment lines from those registers.

---
 rtl/nexys4_display_axi_slave_if.sv | 48 ++++
 rtl/nexys4_display_axi_slave.sv | 164 ++++++++++++++++
 tb/tb_nexys4_display_axi_slave.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nexys4_display_axi_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : nexys4_display_axi_slave_if
// Description : AXI4-Lite control-port bundle for the Nexys4 display responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface nexys4_display_axi_slave_if #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4
);
  // Write address channel
  logic [C_S00_AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]                        awprot;
  logic                              awvalid;
  logic                              awready;
  // Write data channel
  logic [C_S00_AXI_DATA_WIDTH-1:0]   wdata;
  logic [C_S00_AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                              wvalid;
  logic                              wready;
  // Write response channel
  logic [1:0]                        bresp;
  logic                              bvalid;
  logic                              bready;
  // Read address channel
  logic [C_S00_AXI_ADDR_WIDTH-1:0]   araddr;
  logic [2:0]                        arprot;
  logic                              arvalid;
  logic                              arready;
  // Read data channel
  logic [C_S00_AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                        rresp;
  logic                              rvalid;
  logic                              rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/nexys4_display_axi_slave.sv
`default_nettype none
// ============================================================================
// Module      : nexys4_display_axi_slave
// Description : AXI4-Lite responder with four 32-bit registers driving a
//               prescaled, time-multiplexed eight-digit seven-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
module nexys4_display_axi_slave #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 4
) (
  input  wire logic                      s00_axi_aclk,
  input  wire logic                      s00_axi_aresetn,
  nexys4_display_axi_slave_if.slave      s00_axi,
  output logic [7:0]                     an,
  output logic [6:0]                     seg,
  output logic                           dp
);

  localparam int c_NBYTES = C_S00_AXI_DATA_WIDTH / 8;

  // Register file: 0 digits, 1 enables, 2 dots, 3 prescale
  logic [C_S00_AXI_DATA_WIDTH-1:0] r_regs [4];

  logic                            r_awready;
  logic                            r_bvalid;
  logic                            r_arready;
  logic                            r_rvalid;
  logic [C_S00_AXI_DATA_WIDTH-1:0] r_rdata;

  logic [31:0]                     r_presc;
  logic [2:0]                      r_idx;

  logic                            w_wr_en;
  logic                            w_rd_en;
  logic [1:0]                      w_wr_sel;
  logic [1:0]                      w_rd_sel;
  logic                            w_tick;
  logic                            w_digit_en;
  logic [3:0]                      w_nibble;
  logic [6:0]                      w_hex_seg;
  logic                            w_unused;

  // Handshake edge: ready is high and the master still presents both valids
  assign w_wr_en  = r_awready & s00_axi.awvalid & s00_axi.wvalid;
  assign w_rd_en  = r_arready & s00_axi.arvalid;
  assign w_wr_sel = s00_axi.awaddr[3:2];
  assign w_rd_sel = s00_axi.araddr[3:2];

  assign s00_axi.awready = r_awready;
  assign s00_axi.wready  = r_awready;
  assign s00_axi.bvalid  = r_bvalid;
  assign s00_axi.bresp   = 2'b00;
  assign s00_axi.arready = r_arready;
  assign s00_axi.rvalid  = r_rvalid;
  assign s00_axi.rdata   = r_rdata;
  assign s00_axi.rresp   = 2'b00;

  // Protection bits and the byte offset within a word carry no meaning here
  assign w_unused = ^{s00_axi.awprot, s00_axi.arprot,
                      s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

  // Write channel: one-cycle AW/W ready pulse, then a held B response
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= s00_axi.awvalid & s00_axi.wvalid & ~r_awready & ~r_bvalid;
      if (w_wr_en)
        r_bvalid <= 1'b1;
      else if (s00_axi.bready)
        r_bvalid <= 1'b0;
    end
  end

  // Register file update with per-byte strobes
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int r = 0; r < 4; r++)
        r_regs[r] <= '0;
    end else if (w_wr_en) begin
      for (int k = 0; k < c_NBYTES; k++)
        if (s00_axi.wstrb[k])
          r_regs[w_wr_sel][8*k +: 8] <= s00_axi.wdata[8*k +: 8];
    end
  end

  // Read channel: data captured on the AR handshake edge, so a colliding
  // write to the same register is not yet visible and the old value returns
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= s00_axi.arvalid & ~r_arready & ~r_rvalid;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= r_regs[w_rd_sel];
      end else if (s00_axi.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Prescaler wraps on equality only; a lowered limit just rolls over
  assign w_tick = (r_presc == r_regs[3]);

  // Scan timing: prescaler and digit index
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_idx   <= r_idx + 3'd1;
    end else begin
      r_presc <= r_presc + 32'd1;
    end
  end

  assign w_digit_en = r_regs[1][r_idx];
  assign w_nibble   = r_regs[0][{r_idx, 2'b00} +: 4];

  // Hex to active-low {g,f,e,d,c,b,a} decoder
  always_comb begin
    w_hex_seg = 7'h7F;
    case (w_nibble)
      4'h0: w_hex_seg = 7'h40;
      4'h1: w_hex_seg = 7'h79;
      4'h2: w_hex_seg = 7'h24;
      4'h3: w_hex_seg = 7'h30;
      4'h4: w_hex_seg = 7'h19;
      4'h5: w_hex_seg = 7'h12;
      4'h6: w_hex_seg = 7'h02;
      4'h7: w_hex_seg = 7'h78;
      4'h8: w_hex_seg = 7'h00;
      4'h9: w_hex_seg = 7'h10;
      4'hA: w_hex_seg = 7'h08;
      4'hB: w_hex_seg = 7'h03;
      4'hC: w_hex_seg = 7'h46;
      4'hD: w_hex_seg = 7'h21;
      4'hE: w_hex_seg = 7'h06;
      4'hF: w_hex_seg = 7'h0E;
      default: w_hex_seg = 7'h7F;
    endcase
  end

  // Registered display drive for the current digit; disabled digits go dark
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~({7'b0, w_digit_en} << r_idx);
      seg <= w_digit_en ? w_hex_seg : 7'h7F;
      dp  <= ~(r_regs[2][r_idx] & w_digit_en);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nexys4_display_axi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_nexys4_display_axi_slave
// Description : Self-checking bench: register table, strobes, back-pressure,
//               reset mid-read and display scan sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nexys4_display_axi_slave;

  logic       clk;
  logic       rst_n;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_fail   = 0;

  nexys4_display_axi_slave_if #(.C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(4)) axi ();

  nexys4_display_axi_slave #(
    .C_S00_AXI_DATA_WIDTH(32),
    .C_S00_AXI_ADDR_WIDTH(4)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi         (axi),
    .an              (an),
    .seg             (seg),
    .dp              (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int n;
    @(negedge clk);
    axi.awaddr  = addr;
    axi.wdata   = data;
    axi.wstrb   = strb;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    n = 0;
    while (axi.awready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("awready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    n = 0;
    while (axi.bvalid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("bvalid_timeout", 32'd0, 32'd1);
    check("bresp", {30'd0, axi.bresp}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int n;
    @(negedge clk);
    axi.araddr  = addr;
    axi.arvalid = 1'b1;
    n = 0;
    while (axi.arready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("arready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    axi.arvalid = 1'b0;
    n = 0;
    while (axi.rvalid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check("rvalid_timeout", 32'd0, 32'd1);
    check("rresp", {30'd0, axi.rresp}, 32'd0);
    data = axi.rdata;
  endtask

  function automatic vec_t mk(bit rd, logic [3:0] a, logic [31:0] d, logic [3:0] s, logic [31:0] e);
    vec_t v;
    v.is_read = rd; v.addr = a; v.data = d; v.strb = s; v.exp = e;
    return v;
  endfunction

  initial begin
    vec_t        vecs [15];
    logic [31:0] rd;
    logic [6:0]  hex_tab [16];
    logic [7:0]  prev_an;
    logic [7:0]  exp_an;
    bit          found;
    int          n;

    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    vecs[0]  = mk(0, 4'h0, 32'd1, 4'hF, 32'd0);
    vecs[1]  = mk(0, 4'h4, 32'd2, 4'hF, 32'd0);
    vecs[2]  = mk(0, 4'h8, 32'd3, 4'hF, 32'd0);
    vecs[3]  = mk(0, 4'hC, 32'd4, 4'hF, 32'd0);
    vecs[4]  = mk(1, 4'h0, 32'd0, 4'h0, 32'd1);
    vecs[5]  = mk(1, 4'h4, 32'd0, 4'h0, 32'd2);
    vecs[6]  = mk(1, 4'h8, 32'd0, 4'h0, 32'd3);
    vecs[7]  = mk(1, 4'hC, 32'd0, 4'h0, 32'd4);
    vecs[8]  = mk(0, 4'h0, 32'hFFFF_FFFF, 4'hF, 32'd0);
    vecs[9]  = mk(0, 4'h0, 32'h0000_00AB, 4'b0001, 32'd0);
    vecs[10] = mk(1, 4'h0, 32'd0, 4'h0, 32'hFFFF_FFAB);
    vecs[11] = mk(0, 4'h5, 32'h1234_5678, 4'b1100, 32'd0);
    vecs[12] = mk(1, 4'h4, 32'd0, 4'h0, 32'h1234_0002);
    vecs[13] = mk(0, 4'hB, 32'hAABB_CCDD, 4'b0110, 32'd0);
    vecs[14] = mk(1, 4'h8, 32'd0, 4'h0, 32'h00BB_CC03);

    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata  = '0; axi.wstrb  = '0; axi.wvalid  = 1'b0;
    axi.bready = 1'b1;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0;
    axi.rready = 1'b1;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_an",     {24'd0, an}, 32'h0000_00FF);
    check("reset_seg",    {25'd0, seg}, 32'h0000_007F);
    check("reset_dp",     {31'd0, dp}, 32'd1);
    check("reset_valids", {28'd0, axi.awready, axi.bvalid, axi.arready, axi.rvalid}, 32'd0);
    rst_n = 1'b1;

    // Table-driven register access
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].is_read) begin
        axi_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      end else begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      end
    end

    // Write response back-pressure blocks a second write
    axi.bready = 1'b0;
    axi_write(4'h0, 32'h1111_1111, 4'hF);
    @(negedge clk);
    axi.awaddr = 4'h0; axi.wdata = 32'h2222_2222; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_bvalid_held", {31'd0, axi.bvalid}, 32'd1);
      check("bp_awready_low", {31'd0, axi.awready}, 32'd0);
    end
    axi.bready = 1'b1;
    axi_write(4'h0, 32'h2222_2222, 4'hF);
    axi_read(4'h0, rd);
    check("bp_second_write", rd, 32'h2222_2222);

    // Reset between arready and rready
    axi.rready = 1'b0;
    @(negedge clk);
    axi.araddr = 4'h0; axi.arvalid = 1'b1;
    n = 0;
    while (axi.arready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    axi.arvalid = 1'b0;
    check("midread_rvalid_up", {31'd0, axi.rvalid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midread_rvalid_drop", {31'd0, axi.rvalid}, 32'd0);
    check("midread_an", {24'd0, an}, 32'h0000_00FF);
    @(negedge clk);
    rst_n = 1'b1;
    axi.rready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      axi_read(4'(r * 4), rd);
      check($sformatf("post_reset_reg%0d", r), rd, 32'd0);
    end

    // Scan sequence: digit i shows i, dot only on digit 0, 4-cycle period
    axi_write(4'h0, 32'h7654_3210, 4'hF);
    axi_write(4'h8, 32'h0000_0001, 4'hF);
    axi_write(4'hC, 32'd3, 4'hF);
    axi_write(4'h4, 32'h0000_00FF, 4'hF);
    prev_an = an;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(negedge clk);
      if (an == 8'hFE && prev_an == 8'h7F) found = 1'b1;
      else prev_an = an;
    end
    check("scan_sync", {31'd0, found}, 32'd1);
    if (found) begin
      for (int k = 0; k < 9; k++) begin
        exp_an = ~(8'd1 << (k % 8));
        check($sformatf("scan%0d_an", k),  {24'd0, an},  {24'd0, exp_an});
        check($sformatf("scan%0d_seg", k), {25'd0, seg}, {25'd0, hex_tab[k % 8]});
        check($sformatf("scan%0d_dp", k),  {31'd0, dp},  (k % 8 == 0) ? 32'd0 : 32'd1);
        repeat (3) @(negedge clk);
        check($sformatf("scan%0d_an_hold", k), {24'd0, an}, {24'd0, exp_an});
        @(negedge clk);
      end
    end

    // All digits disabled: dark across a full scan
    axi_write(4'h4, 32'h0000_0000, 4'hF);
    repeat (6) @(negedge clk);
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (c % 4 == 0) begin
        check("dark_an",  {24'd0, an},  32'h0000_00FF);
        check("dark_seg", {25'd0, seg}, 32'h0000_007F);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
